// File: rtl/conv3x3_pe_array_if.sv
// Bus bundle for conv3x3_pe_array: weight loading, row windows and conv results.
// master = upstream driver (line buffer / weight loader), slave = the PE array.
interface conv3x3_pe_array_if;
    logic        i_w_clear;
    logic        i_w_valid;
    logic [7:0]  i_w_data;
    logic        o_w_ready;
    logic [23:0] i_pe_1_row;
    logic [23:0] i_pe_2_row;
    logic [23:0] i_pe_3_row;
    logic [23:0] i_pe_4_row;
    logic [23:0] i_pe_5_row;
    logic        i_pe_valid;
    logic        i_row_done;
    logic [19:0] o_out_0;
    logic [19:0] o_out_1;
    logic [19:0] o_out_2;
    logic        o_out_valid;
    logic        o_row_end;
    logic [5:0]  o_col_cnt;
    logic        o_err_no_weight;

    modport master (
        output i_w_clear, i_w_valid, i_w_data,
        output i_pe_1_row, i_pe_2_row, i_pe_3_row, i_pe_4_row, i_pe_5_row,
        output i_pe_valid, i_row_done,
        input  o_w_ready, o_out_0, o_out_1, o_out_2,
        input  o_out_valid, o_row_end, o_col_cnt, o_err_no_weight
    );

    modport slave (
        input  i_w_clear, i_w_valid, i_w_data,
        input  i_pe_1_row, i_pe_2_row, i_pe_3_row, i_pe_4_row, i_pe_5_row,
        input  i_pe_valid, i_row_done,
        output o_w_ready, o_out_0, o_out_1, o_out_2,
        output o_out_valid, o_row_end, o_col_cnt, o_err_no_weight
    );
endinterface

// File: rtl/conv3x3_pe_array.sv
// Three vertically adjacent 3x3 convolutions over five row windows, 3-stage pipeline.
// Optional CONV_RELU_EN: clamp negative results to zero in the last stage.
module conv3x3_pe_array (
    input  logic                 clk,
    input  logic                 rstn,
    conv3x3_pe_array_if.slave    bus
);
    typedef enum logic [1:0] {W_EMPTY, W_LOADING, W_READY} w_state_t;

    w_state_t           state, state_nxt;
    logic               w_wr;
    logic [3:0]         w_cnt;
    logic signed [7:0]  w [9];
    logic               ready;
    logic               accept;
    logic [23:0]        rows [5];

    logic signed [15:0] prod [3][3][3];
    logic signed [17:0] rsum [3][3];
    logic signed [19:0] tot  [3];
    logic signed [19:0] res  [3];
    logic signed [19:0] out_q [3];
    logic               v1, v2, out_valid;
    logic               rd1, rd2, row_end;
    logic [5:0]         col_cnt;
    logic               err;

    function automatic logic signed [15:0] mul(input logic [7:0] px, input logic signed [7:0] wt);
        return $signed({1'b0, px}) * wt;
    endfunction

    always_ff @(posedge clk) begin
        if (!rstn) state <= W_EMPTY;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        w_wr      = 1'b0;
        if (bus.i_w_clear) begin
            state_nxt = W_EMPTY;
        end else begin
            case (state)
                W_EMPTY: if (bus.i_w_valid) begin
                    w_wr      = 1'b1;
                    state_nxt = W_LOADING;
                end
                W_LOADING: if (bus.i_w_valid) begin
                    w_wr = 1'b1;
                    if (w_cnt == 4'd8) state_nxt = W_READY;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn || bus.i_w_clear) begin
            w_cnt <= '0;
            for (int unsigned i = 0; i < 9; i++) w[i] <= '0;
        end else if (w_wr) begin
            w[w_cnt] <= bus.i_w_data;
            w_cnt    <= w_cnt + 4'd1;
        end
    end

    assign ready  = (state == W_READY);
    assign accept = bus.i_pe_valid && ready;

    always_comb begin
        rows[0] = bus.i_pe_1_row;
        rows[1] = bus.i_pe_2_row;
        rows[2] = bus.i_pe_3_row;
        rows[3] = bus.i_pe_4_row;
        rows[4] = bus.i_pe_5_row;
    end

    // Valid and row-end markers travel on their own reset pipeline; data stages are enable-only.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            v1        <= 1'b0;
            v2        <= 1'b0;
            out_valid <= 1'b0;
            rd1       <= 1'b0;
            rd2       <= 1'b0;
            row_end   <= 1'b0;
        end else begin
            v1        <= accept;
            v2        <= v1;
            out_valid <= v2;
            rd1       <= bus.i_row_done;
            rd2       <= rd1;
            row_end   <= rd2;
        end
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            for (int unsigned k = 0; k < 3; k++)
                for (int unsigned r = 0; r < 3; r++)
                    for (int unsigned c = 0; c < 3; c++)
                        prod[k][r][c] <= mul(rows[k+r][23-8*c -: 8], w[r*3+c]);
        end
    end

    always_ff @(posedge clk) begin
        if (v1) begin
            for (int unsigned k = 0; k < 3; k++)
                for (int unsigned r = 0; r < 3; r++)
                    rsum[k][r] <= 18'(prod[k][r][0]) + 18'(prod[k][r][1]) + 18'(prod[k][r][2]);
        end
    end

    always_comb begin
        for (int unsigned k = 0; k < 3; k++) begin
            tot[k] = 20'(rsum[k][0]) + 20'(rsum[k][1]) + 20'(rsum[k][2]);
`ifdef CONV_RELU_EN
            res[k] = tot[k][19] ? '0 : tot[k];
`else
            res[k] = tot[k];
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            for (int unsigned k = 0; k < 3; k++) out_q[k] <= '0;
        end else if (v2) begin
            for (int unsigned k = 0; k < 3; k++) out_q[k] <= res[k];
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            col_cnt <= '0;
            err     <= 1'b0;
        end else begin
            if (row_end)        col_cnt <= '0;
            else if (out_valid) col_cnt <= col_cnt + 6'd1;
            if (bus.i_pe_valid && !ready) err <= 1'b1;
        end
    end

    assign bus.o_w_ready       = ready;
    assign bus.o_out_0         = out_q[0];
    assign bus.o_out_1         = out_q[1];
    assign bus.o_out_2         = out_q[2];
    assign bus.o_out_valid     = out_valid;
    assign bus.o_row_end       = row_end;
    assign bus.o_col_cnt       = col_cnt;
    assign bus.o_err_no_weight = err;
endmodule

// File: tb/tb_conv3x3_pe_array.sv
// Self-checking bench for conv3x3_pe_array: directed cases plus a randomized row
// stream checked against an arithmetic convolution model (honours CONV_RELU_EN).
module tb_conv3x3_pe_array;
    localparam int N = 48;

    logic clk = 1'b0;
    logic rstn;
    always #5 clk = ~clk;

    conv3x3_pe_array_if bus();
    conv3x3_pe_array dut (.clk(clk), .rstn(rstn), .bus(bus));

    int          n_tests = 0;
    int          n_fail  = 0;
    int          mw [9];
    logic [23:0] mrows [5];

    // Reference: out_k = sum over r,c of pixel(row k+r+1, byte c) * w[r*3+c]
    function automatic logic [19:0] model_out(input int k);
        int s;
        s = 0;
        for (int r = 0; r < 3; r++)
            for (int c = 0; c < 3; c++) begin
                logic [23:0] rw;
                logic [7:0]  px;
                rw = mrows[k+r];
                px = rw[23-8*c -: 8];
                s += int'(px) * mw[r*3+c];
            end
`ifdef CONV_RELU_EN
        if (s < 0) s = 0;
`endif
        return s[19:0];
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.i_w_clear  = 1'b0;
        bus.i_w_valid  = 1'b0;
        bus.i_w_data   = '0;
        bus.i_pe_1_row = '0;
        bus.i_pe_2_row = '0;
        bus.i_pe_3_row = '0;
        bus.i_pe_4_row = '0;
        bus.i_pe_5_row = '0;
        bus.i_pe_valid = 1'b0;
        bus.i_row_done = 1'b0;
    endtask

    task automatic apply_reset();
        idle_inputs();
        rstn = 1'b0;
        tick();
        rstn = 1'b1;
        for (int i = 0; i < 9; i++) mw[i] = 0;
    endtask

    task automatic load_weights(input int wv [9]);
        bus.i_w_clear = 1'b1;
        tick();
        bus.i_w_clear = 1'b0;
        for (int i = 0; i < 9; i++) begin
            bus.i_w_valid = 1'b1;
            bus.i_w_data  = 8'(wv[i]);
            mw[i] = wv[i];
            tick();
        end
        bus.i_w_valid = 1'b0;
    endtask

    task automatic drive_window(input logic [23:0] r [5], input logic rd);
        for (int i = 0; i < 5; i++) mrows[i] = r[i];
        bus.i_pe_1_row = r[0];
        bus.i_pe_2_row = r[1];
        bus.i_pe_3_row = r[2];
        bus.i_pe_4_row = r[3];
        bus.i_pe_5_row = r[4];
        bus.i_pe_valid = 1'b1;
        bus.i_row_done = rd;
    endtask

    task automatic test_reset();
        apply_reset();
        n_tests++;
        if ({bus.o_w_ready, bus.o_out_valid, bus.o_row_end, bus.o_err_no_weight, bus.o_col_cnt} !== 10'd0) begin
            n_fail++;
            $display("FAIL reset_ctrl got %b exp 0", {bus.o_w_ready, bus.o_out_valid, bus.o_row_end, bus.o_err_no_weight, bus.o_col_cnt});
        end
        n_tests++;
        if ({bus.o_out_0, bus.o_out_1, bus.o_out_2} !== 60'd0) begin
            n_fail++;
            $display("FAIL reset_outs got %h exp 0", {bus.o_out_0, bus.o_out_1, bus.o_out_2});
        end
    endtask

    // Single window, checks latency 3 (not valid one edge early) and the values.
    task automatic run_single(input string name, input logic [23:0] r [5], input logic [19:0] exp_out [3]);
        drive_window(r, 1'b0);
        tick();
        bus.i_pe_valid = 1'b0;
        tick();
        n_tests++;
        if (bus.o_out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL %s_early_valid got %b exp 0", name, bus.o_out_valid);
        end
        tick();
        n_tests++;
        if ({bus.o_out_valid, bus.o_out_0, bus.o_out_1, bus.o_out_2} !== {1'b1, exp_out[0], exp_out[1], exp_out[2]}) begin
            n_fail++;
            $display("FAIL %s got v=%b %h %h %h exp v=1 %h %h %h", name, bus.o_out_valid,
                     bus.o_out_0, bus.o_out_1, bus.o_out_2, exp_out[0], exp_out[1], exp_out[2]);
        end
        tick();
        n_tests++;
        if ({bus.o_out_valid, bus.o_out_0} !== {1'b0, exp_out[0]}) begin
            n_fail++;
            $display("FAIL %s_hold got v=%b %h exp v=0 %h", name, bus.o_out_valid, bus.o_out_0, exp_out[0]);
        end
    endtask

    task automatic test_ones();
        int          wv [9];
        logic [23:0] r [5];
        logic [19:0] e [3];
        for (int i = 0; i < 9; i++) wv[i] = 1;
        load_weights(wv);
        n_tests++;
        if (bus.o_w_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL ones_ready got %b exp 1", bus.o_w_ready);
        end
        for (int i = 0; i < 5; i++) r[i] = 24'h010203;
        for (int k = 0; k < 3; k++) e[k] = 20'd18;
        run_single("ones", r, e);
    endtask

    task automatic test_center();
        int          wv [9];
        logic [23:0] r [5];
        logic [19:0] e [3];
        for (int i = 0; i < 9; i++) wv[i] = 0;
        wv[4] = 2;
        load_weights(wv);
        for (int i = 0; i < 5; i++) begin
            logic [7:0] a, b;
            a = 8'($urandom);
            b = 8'($urandom);
            r[i] = {a, 8'(10 * (i + 1)), b};
        end
        e[0] = 20'd40;
        e[1] = 20'd60;
        e[2] = 20'd80;
        run_single("center", r, e);
    endtask

    task automatic test_neg();
        int          wv [9];
        logic [23:0] r [5];
        logic [19:0] e [3];
        for (int i = 0; i < 9; i++) wv[i] = -1;
        load_weights(wv);
        for (int i = 0; i < 5; i++) r[i] = 24'hFFFFFF;
`ifdef CONV_RELU_EN
        for (int k = 0; k < 3; k++) e[k] = 20'h00000;
`else
        for (int k = 0; k < 3; k++) e[k] = 20'hFF709;
`endif
        run_single("neg", r, e);
    endtask

    task automatic test_clear_err();
        logic [23:0] r [5];
        int          wv [9];
        int          seen;
        apply_reset();
        for (int i = 0; i < 5; i++) begin
            bus.i_w_valid = 1'b1;
            bus.i_w_data  = 8'(i + 1);
            tick();
        end
        bus.i_w_valid = 1'b0;
        n_tests++;
        if (bus.o_w_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL partial_ready got %b exp 0", bus.o_w_ready);
        end
        bus.i_w_clear = 1'b1;
        bus.i_w_valid = 1'b1;
        tick();
        bus.i_w_clear = 1'b0;
        bus.i_w_valid = 1'b0;
        for (int i = 0; i < 5; i++) r[i] = 24'h111111;
        drive_window(r, 1'b0);
        tick();
        bus.i_pe_valid = 1'b0;
        n_tests++;
        if ({bus.o_w_ready, bus.o_err_no_weight} !== 2'b01) begin
            n_fail++;
            $display("FAIL clear_err got ready/err=%b exp 01", {bus.o_w_ready, bus.o_err_no_weight});
        end
        seen = 0;
        for (int i = 0; i < 5; i++) begin
            tick();
            if (bus.o_out_valid === 1'b1) seen++;
        end
        n_tests++;
        if (seen !== 0) begin
            n_fail++;
            $display("FAIL dropped_window got %0d beats exp 0", seen);
        end
        for (int i = 0; i < 9; i++) wv[i] = i - 4;
        load_weights(wv);
        n_tests++;
        if ({bus.o_w_ready, bus.o_err_no_weight} !== 2'b11) begin
            n_fail++;
            $display("FAIL reload got ready/err=%b exp 11", {bus.o_w_ready, bus.o_err_no_weight});
        end
    endtask

    task automatic test_row_end();
        bus.i_row_done = 1'b1;
        tick();
        bus.i_row_done = 1'b0;
        tick();
        n_tests++;
        if (bus.o_row_end !== 1'b0) begin
            n_fail++;
            $display("FAIL row_end_early got %b exp 0", bus.o_row_end);
        end
        tick();
        n_tests++;
        if ({bus.o_row_end, bus.o_out_valid} !== 2'b10) begin
            n_fail++;
            $display("FAIL row_end_alone got re/v=%b exp 10", {bus.o_row_end, bus.o_out_valid});
        end
        tick();
        n_tests++;
        if ({bus.o_row_end, bus.o_col_cnt} !== 7'd0) begin
            n_fail++;
            $display("FAIL row_end_after got re=%b col=%0d exp 0 0", bus.o_row_end, bus.o_col_cnt);
        end
    endtask

    task automatic test_back_to_back();
        int          wv [9];
        logic [23:0] r [5];
        logic [19:0] e0 [N];
        logic [19:0] e1 [N];
        logic [19:0] e2 [N];
        apply_reset();
        for (int i = 0; i < 9; i++) wv[i] = int'($urandom_range(0, 255)) - 128;
        load_weights(wv);
        for (int t = 0; t <= N + 2; t++) begin
            if (t < N) begin
                for (int i = 0; i < 5; i++) r[i] = 24'($urandom);
                drive_window(r, t == N - 1);
                e0[t] = model_out(0);
                e1[t] = model_out(1);
                e2[t] = model_out(2);
            end else begin
                bus.i_pe_valid = 1'b0;
                bus.i_row_done = 1'b0;
            end
            tick();
            if (t >= 2) begin
                int j;
                j = t - 2;
                n_tests++;
                if (j < N) begin
                    if ({bus.o_out_valid, bus.o_out_0, bus.o_out_1, bus.o_out_2, bus.o_col_cnt, bus.o_row_end} !==
                        {1'b1, e0[j], e1[j], e2[j], 6'(j), (j == N - 1)}) begin
                        n_fail++;
                        $display("FAIL stream[%0d] got v=%b %h %h %h col=%0d re=%b exp v=1 %h %h %h col=%0d re=%b",
                                 j, bus.o_out_valid, bus.o_out_0, bus.o_out_1, bus.o_out_2, bus.o_col_cnt,
                                 bus.o_row_end, e0[j], e1[j], e2[j], j, (j == N - 1));
                    end
                end else begin
                    if ({bus.o_out_valid, bus.o_row_end, bus.o_col_cnt} !== 8'd0) begin
                        n_fail++;
                        $display("FAIL stream_end got v=%b re=%b col=%0d exp 0 0 0",
                                 bus.o_out_valid, bus.o_row_end, bus.o_col_cnt);
                    end
                end
            end
        end
    endtask

    task automatic test_reset_midflight();
        logic [23:0] r [5];
        int          seen;
        for (int i = 0; i < 5; i++) r[i] = 24'($urandom) | 24'h010101;
        drive_window(r, 1'b1);
        tick();
        drive_window(r, 1'b0);
        tick();
        bus.i_pe_valid = 1'b0;
        rstn = 1'b0;
        tick();
        rstn = 1'b1;
        seen = 0;
        for (int i = 0; i < 5; i++) begin
            if (bus.o_out_valid === 1'b1 || bus.o_row_end === 1'b1) seen++;
            tick();
        end
        n_tests++;
        if (seen !== 0) begin
            n_fail++;
            $display("FAIL midflight_beats got %0d exp 0", seen);
        end
        n_tests++;
        if ({bus.o_out_0, bus.o_out_1, bus.o_out_2, bus.o_w_ready, bus.o_err_no_weight, bus.o_col_cnt} !== 68'd0) begin
            n_fail++;
            $display("FAIL midflight_state got %h exp 0",
                     {bus.o_out_0, bus.o_out_1, bus.o_out_2, bus.o_w_ready, bus.o_err_no_weight, bus.o_col_cnt});
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got timeout exp finish");
        $fatal(1, "watchdog");
    end

    initial begin
        idle_inputs();
        rstn = 1'b0;
        tick();
        test_reset();
        test_ones();
        test_center();
        test_neg();
        test_clear_err();
        test_row_end();
        test_back_to_back();
        test_reset_midflight();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/conv3x3_pe_array.md
# conv3x3_pe_array

Three-output 3x3 convolution engine that sits directly downstream of the image line buffer. Each valid cycle it takes five 3-pixel row windows (rows 1..5, 8-bit unsigned pixels) and computes three vertically adjacent 3x3 dot products: output k uses rows k+1..k+3. It uses one set of nine signed 8-bit weights, loaded serially. Results leave as 20-bit signed sums through a 3-stage pipeline, with row-end markers carried alongside.

## Interface
Parameters:
- none; all widths are fixed.

Ports:
- clk  in  1  clock
- rstn  in  1  reset, synchronous, active-low
- i_w_clear  in  1  discard loaded weights; return weight FSM to W_EMPTY
- i_w_valid  in  1  weight byte strobe
- i_w_data  in  8  signed weight, raster order w0..w8 (w[r*3+c])
- o_w_ready  out  1  all 9 weights loaded; compute enabled
- i_pe_1_row .. i_pe_5_row  in  24 each  row window; byte c=0 is [23:16] (oldest), c=2 is [7:0] (newest)
- i_pe_valid  in  1  row windows valid this cycle
- i_row_done  in  1  image-row boundary pulse from line buffer
- o_out_0, o_out_1, o_out_2  out  20 each  signed conv results for rows 1-3, 2-4, 3-5
- o_out_valid  out  1  outputs valid
- o_row_end  out  1  i_row_done delayed to output timing
- o_col_cnt  out  6  index of the current output column within the row
- o_err_no_weight  out  1  sticky; i_pe_valid seen while o_w_ready=0

## Operation
- Weight FSM states:
  - W_EMPTY to W_LOADING on the first i_w_valid.
  - W_LOADING to W_READY when the 9th byte is written (w_cnt==8 && i_w_valid).
  - Any state to W_EMPTY on i_w_clear.
- i_w_clear has priority over i_w_valid in the same cycle; that byte is dropped and w_cnt is set to 0.
- i_w_valid in W_READY is ignored.
- o_w_ready = (state==W_READY).
- Compute is accepted only when i_pe_valid && o_w_ready. A window presented while not ready is dropped and sets o_err_no_weight. That flag clears only on reset.
- Stage 1: 27 products. Each is p = $signed({1'b0,pixel}) * w, 16-bit signed, exact.
  - Product (k,r,c) = byte c of row k+r+1, multiplied by w[r*3+c].
- Stage 2: nine row sums, 18-bit signed (sign-extended, no overflow possible).
- Stage 3: out_k = sum of its three row sums, 20-bit signed, exact.
- Weights are sampled at stage 1. An i_w_clear or reload never corrupts windows already in flight; they complete with the old weights.
- o_col_cnt:
  - increments after each o_out_valid beat;
  - resets to 0 on the cycle after o_row_end;
  - wraps 63→0.
- o_row_end: i_row_done delayed by exactly 3 cycles, independent of o_out_valid.

## Timing
- Latency: a window accepted at cycle N gives o_out_valid and results at N+3. Full throughput is 1 window per cycle, with no stall path.
- o_out_* hold their last value when o_out_valid=0.
- Reset values:
  - o_out_0/1/2 = 0; o_out_valid = 0; o_row_end = 0; o_col_cnt = 0; o_err_no_weight = 0; o_w_ready = 0;
  - weight FSM = W_EMPTY, w_cnt = 0, all weights 0;
  - all pipeline valid bits cleared.
- Reset mid-pipeline discards in-flight windows. No output is emitted from pre-reset data.
- i_row_done coincident with i_pe_valid: both are processed. The window counts as the last column of the row, and o_row_end coincides with that output beat. o_col_cnt then reads 0 on the next cycle.

## Configuration
- CONV_RELU_EN defined: stage 3 clamps negative sums to 0 (out_k = sum<0 ? 0 : sum). Latency is unchanged.
- CONV_RELU_EN undefined: raw signed sums are output.

## Test plan
- Load weights 1,1,1,1,1,1,1,1,1. Drive all rows = 24'h010203 with i_pe_valid for 1 cycle → 3 cycles later o_out_valid=1 and o_out_0=o_out_1=o_out_2=18.
- Load w4=2, all others 0. Drive rows 1..5 with centre byte [15:8] = 10,20,30,40,50 → outs = 40,60,80 at latency 3.
- Load all weights = -1. Drive all pixels = 255 → sum = -2295. Without the macro, outs = 20'hFF709. With CONV_RELU_EN, outs = 0.
- Send 5 weights, pulse i_w_clear, then i_pe_valid → o_w_ready=0, o_err_no_weight=1, no o_out_valid. Reload 9 weights → o_w_ready=1.
- Stream 48 back-to-back windows, with i_row_done on the 48th → o_col_cnt counts 0..47, o_row_end coincides with the 48th output, o_col_cnt=0 on the following cycle.
- Assert rstn=0 for one cycle while 2 windows are in flight → no o_out_valid afterwards; all outputs read 0 and o_w_ready=0.
